// File: rtl/adsr_pkg.sv
// adsr_pkg: shared definitions for the polyphonic ADSR envelope generator.
// Holds the per-voice state encoding and its width.
package adsr_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_t;

endpackage

// File: rtl/adsr_voice.sv
// adsr_voice: one ADSR envelope channel.
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   a/d/r_interval              - step period minus 1 for attack/decay/release
//   sus_lvl                     - sustain level
//   step                        - level change per step (0 behaves as 1)
//   retrig_zero                 - gate rise in RELEASE restarts from 0 when high
//   gate                        - key held
//   out_value, stage, running   - registered level, state code, not-IDLE flag
module adsr_voice
  import adsr_pkg::*;
#(
  parameter int OUT_W      = 8,
  parameter int INTERVAL_W = 16,
  parameter int STEP_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INTERVAL_W-1:0] a_interval,
  input  logic [INTERVAL_W-1:0] d_interval,
  input  logic [INTERVAL_W-1:0] r_interval,
  input  logic [OUT_W-1:0]      sus_lvl,
  input  logic [STEP_W-1:0]     step,
  input  logic                  retrig_zero,
  input  logic                  gate,
  output logic [OUT_W-1:0]      out_value,
  output logic [STATE_W-1:0]    stage,
  output logic                  running
);

  localparam int EW = OUT_W + 1;
  localparam logic [EW-1:0]         MAX_EXT  = {1'b0, {OUT_W{1'b1}}};
  localparam logic [EW-1:0]         STEP_ONE = {{OUT_W{1'b0}}, 1'b1};
  localparam logic [INTERVAL_W-1:0] CNT_ZERO = {INTERVAL_W{1'b0}};
  localparam logic [INTERVAL_W-1:0] CNT_ONE  = {{(INTERVAL_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0]      LVL_ZERO = {OUT_W{1'b0}};

  adsr_state_t           state, state_n;
  logic [OUT_W-1:0]      level, level_n;
  logic [INTERVAL_W-1:0] cnt, cnt_n;
  logic                  gate_d;
  logic                  run_flag;

  logic [INTERVAL_W-1:0] interval;
  logic [EW-1:0]         step_ext, level_ext, sus_ext, sum, diff;
  logic                  rise, fall, due;

  assign rise      = gate & ~gate_d;
  assign fall      = ~gate & gate_d;
  assign step_ext  = (step == {STEP_W{1'b0}}) ? STEP_ONE : EW'(step);
  assign level_ext = {1'b0, level};
  assign sus_ext   = {1'b0, sus_lvl};
  assign sum       = level_ext + step_ext;
  assign diff      = level_ext - step_ext;
  // >= rather than == so a shortened interval written mid-stage fires at once
  assign due       = (cnt >= interval);

  // Select the step period of the current timed stage.
  always_comb begin
    interval = CNT_ZERO;
    case (state)
      ATTACK:  interval = a_interval;
      DECAY:   interval = d_interval;
      RELEASE: interval = r_interval;
      default: interval = CNT_ZERO;
    endcase
  end

  // Next-state, next-level and step counter logic.
  always_comb begin
    state_n = state;
    level_n = level;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = ATTACK;
          cnt_n   = CNT_ZERO;
        end else begin
          state_n = IDLE;
        end
      end
      ATTACK: begin
        // A fall drops any step due on the same edge.
        if (fall) begin
          state_n = RELEASE;
          cnt_n   = CNT_ZERO;
        end else if (due) begin
          cnt_n = CNT_ZERO;
          if (sum >= MAX_EXT) begin
            level_n = {OUT_W{1'b1}};
            state_n = DECAY;
          end else begin
            level_n = sum[OUT_W-1:0];
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      DECAY: begin
        if (fall) begin
          state_n = RELEASE;
          cnt_n   = CNT_ZERO;
        end else if (due) begin
          cnt_n = CNT_ZERO;
          // Compare before subtracting so a level at or below sustain clamps too.
          if (level_ext <= sus_ext + step_ext) begin
            level_n = sus_lvl;
            state_n = SUSTAIN;
          end else begin
            level_n = diff[OUT_W-1:0];
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      SUSTAIN: begin
        cnt_n = CNT_ZERO;
        if (fall) begin
          state_n = RELEASE;
        end else begin
          level_n = sus_lvl;
        end
      end
      RELEASE: begin
        if (rise) begin
          state_n = ATTACK;
          cnt_n   = CNT_ZERO;
          level_n = retrig_zero ? LVL_ZERO : level;
        end else if (due) begin
          cnt_n = CNT_ZERO;
          if (level_ext <= step_ext) begin
            level_n = LVL_ZERO;
            state_n = IDLE;
          end else begin
            level_n = diff[OUT_W-1:0];
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        level_n = LVL_ZERO;
        cnt_n   = CNT_ZERO;
      end
    endcase
  end

  // State, level, counter and gate history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      level    <= LVL_ZERO;
      cnt      <= CNT_ZERO;
      gate_d   <= 1'b0;
      run_flag <= 1'b0;
    end else begin
      state    <= state_n;
      level    <= level_n;
      cnt      <= cnt_n;
      gate_d   <= gate;
      run_flag <= (state_n != IDLE);
    end
  end

  assign out_value = level;
  assign stage     = state;
  assign running   = run_flag;

endmodule

// File: rtl/adsr_poly.sv
// adsr_poly: VOICES independent ADSR envelopes sharing one set of timing inputs.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   a/d/r_interval, sus_lvl, step, retrig_zero - shared envelope settings
//   gate[v]               - per-voice key held
//   out_value             - voice v level at [v*OUT_W +: OUT_W]
//   stage                 - voice v state code at [v*STATE_W +: STATE_W]
//   running[v]            - voice v not IDLE
module adsr_poly
  import adsr_pkg::*;
#(
  parameter int VOICES     = 4,
  parameter int OUT_W      = 8,
  parameter int INTERVAL_W = 16,
  parameter int STEP_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [INTERVAL_W-1:0]     a_interval,
  input  logic [INTERVAL_W-1:0]     d_interval,
  input  logic [INTERVAL_W-1:0]     r_interval,
  input  logic [OUT_W-1:0]          sus_lvl,
  input  logic [STEP_W-1:0]         step,
  input  logic                      retrig_zero,
  input  logic [VOICES-1:0]         gate,
  output logic [VOICES*OUT_W-1:0]   out_value,
  output logic [VOICES*STATE_W-1:0] stage,
  output logic [VOICES-1:0]         running
);

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    adsr_voice #(
      .OUT_W      (OUT_W),
      .INTERVAL_W (INTERVAL_W),
      .STEP_W     (STEP_W)
    ) u_voice (
      .clk         (clk),
      .rst_n       (rst_n),
      .a_interval  (a_interval),
      .d_interval  (d_interval),
      .r_interval  (r_interval),
      .sus_lvl     (sus_lvl),
      .step        (step),
      .retrig_zero (retrig_zero),
      .gate        (gate[v]),
      .out_value   (out_value[v*OUT_W +: OUT_W]),
      .stage       (stage[v*STATE_W +: STATE_W]),
      .running     (running[v])
    );
  end

endmodule

// File: doc/adsr_poly.md
# adsr_poly

Parametrised multi-voice ADSR envelope generator, successor to the single-voice 7-bit ADSR in the synth datapath. It provides `VOICES` independent envelopes. Each envelope has a configurable output width, a per-step level increment and a selectable retrigger mode. Each voice drives one amplitude/filter modulation input downstream. The envelope timing registers are shared across voices; each voice has its own gate.

## Interface
- `VOICES`, 4: number of independent envelope channels (1–16).
- `OUT_W`, 8: envelope level width. `MAX` = 2^OUT_W − 1.
- `INTERVAL_W`, 16: width of the stage interval registers.
- `STEP_W`, 4: width of the level step size.

- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `a_interval`  in  INTERVAL_W: attack step period minus 1, in clocks.
- `d_interval`  in  INTERVAL_W: decay step period minus 1.
- `r_interval`  in  INTERVAL_W: release step period minus 1.
- `sus_lvl`  in  OUT_W: sustain level.
- `step`  in  STEP_W: level change per step. 0 is treated as 1.
- `retrig_zero`  in  1: 1 = a gate rise during RELEASE restarts attack from 0; 0 = attack restarts from the current level (legato).
- `gate`  in  VOICES: per-voice gate. High = key held.
- `out_value`  out  VOICES*OUT_W: per-voice level. Voice v occupies `[v*OUT_W +: OUT_W]`.
- `stage`  out  VOICES*3: per-voice state encoding.
- `running`  out  VOICES: high while the voice is not IDLE.

## Operation
- Per-voice state machine with five states: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- Each voice registers `gate_d`. A rise is `gate & ~gate_d`; a fall is `~gate & gate_d`.
- Each voice has a counter `cnt` of width INTERVAL_W. In a timed stage a step fires when `cnt >= interval`; `cnt` then clears, otherwise it increments. Using `>=` means a shorter interval written mid-stage takes effect at once.
- Rise in IDLE: go to ATTACK, clear `cnt`, level held (0).
- ATTACK: on each step, `level = min(level + step, MAX)`. Go to DECAY on the edge that writes MAX.
- DECAY: on each step, `level = max(level − step, sus_lvl)`. Go to SUSTAIN on the edge that writes `sus_lvl`.
  - If `level <= sus_lvl` on entry, the first step writes `sus_lvl` and enters SUSTAIN.
- SUSTAIN: `level` tracks `sus_lvl` every cycle; `cnt` is held at 0.
- Fall in ATTACK, DECAY or SUSTAIN: go to RELEASE and clear `cnt`. The fall takes priority over a step due on the same edge; that step is dropped.
- RELEASE: on each step, `level = (level <= step) ? 0 : level − step`. Go to IDLE on the edge that writes 0.
- Rise in RELEASE: go to ATTACK and clear `cnt`. Level becomes 0 if `retrig_zero`, otherwise it is kept.
- Arithmetic uses OUT_W+1 bits internally. There is no wrap-around in either direction.
- `running = (state != IDLE)`. `stage` and `out_value` are registered state, not combinational.

## Timing
- Reset values, all voices: state IDLE, `out_value` 0, `stage` 0, `running` 0, `cnt` 0, `gate_d` 0.
- A gate held high through reset release is seen as a rise on the first edge after `rst_n` goes high.
- Reset asserted mid-envelope clears everything immediately, asynchronously.
- Latency from gate rise:
  - state is ATTACK after edge E0, with level unchanged;
  - the first step lands on edge E0 + a_interval + 1;
  - steps repeat every interval + 1 clocks.
- A gate fall is in RELEASE after one edge. The first release step follows r_interval + 1 edges later.
- Voices are fully independent; simultaneous events on different voices do not interact.
- Changes to shared inputs apply to all voices from the next edge.

## Structure
- Package `adsr_pkg`: the 3-bit state enum/localparams (IDLE..RELEASE) and the STATE_W=3 constant.
- Sub-module `adsr_voice`: one envelope with scalar gate and outputs. `adsr_poly` instantiates it `VOICES` times in a generate loop and packs the outputs.

## Test plan
- VOICES=2, OUT_W=7, step=1, intervals=1, sus_lvl=8; gate0 rises at E0:
  - E0+110 → out0=55; E0+254 → out0=127, stage DECAY;
  - a further 238 edges → out0=8, stage SUSTAIN;
  - voice1 stays IDLE/0 throughout.
- gate0 falls in SUSTAIN (level 8) → RELEASE after 1 edge; out0=7 after 2 more; out0=0 with running0=0 16 edges after the fall edge.
- step=5, OUT_W=7, a_interval=0: ATTACK levels 5, 10, …, 125, then 127 (saturation).
  - sus_lvl=120, d_interval=0 → decay writes 122, then 120, then SUSTAIN.
- Retrigger during RELEASE at level 40:
  - `retrig_zero`=1 → level 0, ATTACK;
  - `retrig_zero`=0 → level stays 40, next step 41.
- Fall during ATTACK at level 30 on an edge where a step is due → RELEASE with level 30; no 31 is ever output.
- `rst_n` pulled low mid-DECAY with gate high → all outputs 0 asynchronously. After release, ATTACK is entered on the first edge and the envelope restarts from 0.
